// File: rtl/sm83_irq_dispatch.sv
// sm83_irq_dispatch: fixed-priority interrupt dispatch with IME/EI delay, HALT wake-up and vector generation
module sm83_irq_dispatch #(
  parameter int NUM_IRQS   = 8,
  parameter int WORD_SIZE  = 8,
  parameter int VEC_BASE   = 'h40,
  parameter int VEC_STRIDE = 8
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [NUM_IRQS-1:0]  irq_i,
  input  logic                 fetch_boundary_i,
  input  logic                 ei_i,
  input  logic                 di_i,
  input  logic                 reti_i,
  input  logic                 halt_i,
  input  logic                 ack_strobe_i,
  output logic                 dispatch_req_o,
  output logic [WORD_SIZE-1:0] vector_o,
  output logic [NUM_IRQS-1:0]  iack_o,
  output logic                 ime_o,
  output logic                 halted_o,
  output logic                 halt_bug_o
);
  localparam int KW = NUM_IRQS > 1 ? $clog2(NUM_IRQS) : 1;
  if (NUM_IRQS < 1 || NUM_IRQS > 16 || VEC_BASE + (NUM_IRQS - 1) * VEC_STRIDE >= 2 ** WORD_SIZE) begin : g_bad_cfg
    $error("sm83_irq_dispatch: illegal parameter combination");
  end
  typedef enum logic [1:0] {RUN, DISPATCH, HALT} state_e;
  state_e               state_q, state_d;
  logic                 ime_q, ime_d, ime_pend_q, ime_pend_d;
  logic                 dispatch_req_q, dispatch_req_d;
  logic                 halted_q, halted_d, halt_bug_q, halt_bug_d;
  logic [WORD_SIZE-1:0] vector_q, vector_d;
  logic [NUM_IRQS-1:0]  iack_q, iack_d;
  logic [KW-1:0]        k;
  logic                 any_irq;
  assign any_irq = |irq_i;
  // Scanning downward leaves the lowest set index, which is the highest priority.
  always_comb begin
    k = '0;
    for (int i = NUM_IRQS - 1; i >= 0; i--) if (irq_i[i]) k = KW'(i);
  end
  always_comb begin
    state_d        = state_q;
    ime_d          = ime_q;
    ime_pend_d     = ime_pend_q;
    dispatch_req_d = dispatch_req_q;
    vector_d       = vector_q;
    halted_d       = halted_q;
    iack_d         = '0;
    halt_bug_d     = 1'b0;
    case (state_q)
      RUN: begin
        if (fetch_boundary_i && ime_pend_q) begin
          ime_d      = 1'b1;
          ime_pend_d = 1'b0;
        end
        if (ei_i && !ime_d) ime_pend_d = 1'b1;
        if (reti_i) begin
          ime_d      = 1'b1;
          ime_pend_d = 1'b0;
        end
        if (di_i) begin
          ime_d      = 1'b0;
          ime_pend_d = 1'b0;
        end
        // The dispatch decision looks at the IME value from before this edge.
        if (halt_i) begin
          if (!ime_q && any_irq) halt_bug_d = 1'b1;
          else begin
            state_d  = HALT;
            halted_d = 1'b1;
          end
        end else if (fetch_boundary_i && ime_q && any_irq) begin
          state_d        = DISPATCH;
          dispatch_req_d = 1'b1;
          ime_d          = 1'b0;
          ime_pend_d     = 1'b0;
        end
      end
      DISPATCH: if (ack_strobe_i) begin
        vector_d       = any_irq ? WORD_SIZE'(VEC_BASE) + WORD_SIZE'(VEC_STRIDE) * WORD_SIZE'(k) : '0;
        iack_d         = any_irq ? NUM_IRQS'(1) << k : '0;
        dispatch_req_d = 1'b0;
        state_d        = RUN;
      end
      HALT: if (any_irq) begin
        halted_d = 1'b0;
        state_d  = RUN;
      end
      default: state_d = RUN;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q        <= RUN;
      ime_q          <= 1'b0;
      ime_pend_q     <= 1'b0;
      dispatch_req_q <= 1'b0;
      vector_q       <= '0;
      iack_q         <= '0;
      halted_q       <= 1'b0;
      halt_bug_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      ime_q          <= ime_d;
      ime_pend_q     <= ime_pend_d;
      dispatch_req_q <= dispatch_req_d;
      vector_q       <= vector_d;
      iack_q         <= iack_d;
      halted_q       <= halted_d;
      halt_bug_q     <= halt_bug_d;
    end
  end
  assign dispatch_req_o = dispatch_req_q;
  assign vector_o       = vector_q;
  assign iack_o         = iack_q;
  assign ime_o          = ime_q;
  assign halted_o       = halted_q;
  assign halt_bug_o     = halt_bug_q;
endmodule

// File: tb/tb_sm83_irq_dispatch.sv
// tb_sm83_irq_dispatch: scoreboard bench for two configurations (8 channels/stride 8, 16 channels/stride 4)
module tb_sm83_irq_dispatch;
  localparam int RUNNING = 0, DISP = 1, HALTED = 2;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        reset = 1'b1, fb = 1'b0, ei = 1'b0, di = 1'b0, reti = 1'b0, halt = 1'b0, ack = 1'b0;
  logic [15:0] irq = '0;
  logic        dreq8, ime8, halted8, hbug8, dreq16, ime16, halted16, hbug16;
  logic [7:0]  vec8, iack8, vec16;
  logic [15:0] iack16;
  int checks = 0, failures = 0, cyc = 0;
  sm83_irq_dispatch #(.NUM_IRQS(8)) dut8 (
    .clk_i(clk), .reset_i(reset), .irq_i(irq[7:0]), .fetch_boundary_i(fb), .ei_i(ei), .di_i(di),
    .reti_i(reti), .halt_i(halt), .ack_strobe_i(ack), .dispatch_req_o(dreq8), .vector_o(vec8),
    .iack_o(iack8), .ime_o(ime8), .halted_o(halted8), .halt_bug_o(hbug8));
  sm83_irq_dispatch #(.NUM_IRQS(16), .VEC_STRIDE(4)) dut16 (
    .clk_i(clk), .reset_i(reset), .irq_i(irq), .fetch_boundary_i(fb), .ei_i(ei), .di_i(di),
    .reti_i(reti), .halt_i(halt), .ack_strobe_i(ack), .dispatch_req_o(dreq16), .vector_o(vec16),
    .iack_o(iack16), .ime_o(ime16), .halted_o(halted16), .halt_bug_o(hbug16));
  typedef struct packed {
    logic        dreq;
    logic [7:0]  vec;
    logic [15:0] iack;
    logic        ime;
    logic        halted;
    logic        hbug;
  } exp_t;
  exp_t q8[$], q16[$];
  int       m_mode[2];
  bit       m_ime[2], m_pend[2], m_dreq[2], m_halted[2], m_hbug[2];
  bit [7:0] m_vec[2];
  bit [15:0] m_iack[2];
  // Reference model: one call advances channel set u by one clock using the current inputs.
  task automatic model_step(input int u, input logic [15:0] iv, input int stride);
    bit ime0, any;
    ime0 = m_ime[u];
    any = (iv != 16'h0);
    m_iack[u] = '0;
    m_hbug[u] = 1'b0;
    if (reset) begin
      m_mode[u] = RUNNING; m_ime[u] = 0; m_pend[u] = 0; m_dreq[u] = 0; m_vec[u] = '0; m_halted[u] = 0;
    end else if (m_mode[u] == RUNNING) begin
      if (fb && m_pend[u]) begin m_ime[u] = 1; m_pend[u] = 0; end
      if (ei && !m_ime[u]) m_pend[u] = 1;
      if (reti) begin m_ime[u] = 1; m_pend[u] = 0; end
      if (di) begin m_ime[u] = 0; m_pend[u] = 0; end
      if (halt) begin
        if (!ime0 && any) m_hbug[u] = 1;
        else begin m_mode[u] = HALTED; m_halted[u] = 1; end
      end else if (fb && ime0 && any) begin
        m_mode[u] = DISP; m_dreq[u] = 1; m_ime[u] = 0; m_pend[u] = 0;
      end
    end else if (m_mode[u] == DISP) begin
      if (ack) begin
        m_vec[u] = '0;
        for (int i = 0; i < 16; i++)
          if (iv[i]) begin
            m_vec[u] = 8'(64 + i * stride);
            m_iack[u] = 16'(1) << i;
            break;
          end
        m_dreq[u] = 0;
        m_mode[u] = RUNNING;
      end
    end else if (any) begin
      m_halted[u] = 0;
      m_mode[u] = RUNNING;
    end
  endtask
  task automatic drive(input logic r, input logic [15:0] iv, input logic f, input logic e,
                       input logic d, input logic t, input logic h, input logic a);
    @(negedge clk);
    reset = r; irq = iv; fb = f; ei = e; di = d; reti = t; halt = h; ack = a;
    model_step(0, iv & 16'h00FF, 8);
    model_step(1, iv, 4);
    q8.push_back('{m_dreq[0], m_vec[0], m_iack[0], m_ime[0], m_halted[0], m_hbug[0]});
    q16.push_back('{m_dreq[1], m_vec[1], m_iack[1], m_ime[1], m_halted[1], m_hbug[1]});
  endtask
  task automatic idle(input logic [15:0] iv);
    drive(0, iv, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic settle();
    @(posedge clk);
    #2;
  endtask
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic cmp(input string who, input exp_t act, input exp_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle %0d: got dreq=%b vec=%h iack=%h ime=%b halted=%b hbug=%b, expected dreq=%b vec=%h iack=%h ime=%b halted=%b hbug=%b",
               who, cyc, act.dreq, act.vec, act.iack, act.ime, act.halted, act.hbug,
               exp.dreq, exp.vec, exp.iack, exp.ime, exp.halted, exp.hbug);
    end
  endtask
  initial forever begin
    @(posedge clk);
    #1;
    cyc++;
    if (q8.size() > 0) cmp("dut8", '{dreq8, vec8, {8'h0, iack8}, ime8, halted8, hbug8}, q8.pop_front());
    if (q16.size() > 0) cmp("dut16", '{dreq16, vec16, iack16, ime16, halted16, hbug16}, q16.pop_front());
  end
  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    settle();
    chk("reset_ime", {15'h0, ime8}, 16'h0);
    chk("reset_vector", {8'h0, vec8}, 16'h0);
    drive(0, 16'h0000, 0, 0, 0, 1, 0, 0);
    drive(0, 16'h0014, 1, 0, 0, 0, 0, 0);
    settle();
    chk("t1_dreq", {15'h0, dreq8}, 16'h1);
    chk("t1_ime", {15'h0, ime8}, 16'h0);
    idle(16'h0014);
    drive(0, 16'h0014, 0, 0, 0, 0, 0, 1);
    settle();
    chk("t1_vector", {8'h0, vec8}, 16'h0050);
    chk("t1_iack", {8'h0, iack8}, 16'h0004);
    chk("t1_dreq_clr", {15'h0, dreq8}, 16'h0);
    idle(16'h0000);
    settle();
    chk("t1_iack_pulse", {8'h0, iack8}, 16'h0);
    drive(0, 16'h0001, 0, 1, 0, 0, 0, 0);
    drive(0, 16'h0001, 1, 0, 0, 0, 0, 0);
    settle();
    chk("t2_no_dispatch", {15'h0, dreq8}, 16'h0);
    chk("t2_ime_set", {15'h0, ime8}, 16'h1);
    idle(16'h0001);
    drive(0, 16'h0001, 1, 0, 0, 0, 0, 0);
    drive(0, 16'h0001, 0, 0, 0, 0, 0, 1);
    settle();
    chk("t2_vector", {8'h0, vec8}, 16'h0040);
    chk("t2_iack", {8'h0, iack8}, 16'h0001);
    drive(0, 16'h0000, 0, 0, 0, 1, 0, 0);
    drive(0, 16'h0002, 1, 0, 0, 0, 0, 0);
    drive(0, 16'h0000, 0, 0, 0, 0, 0, 1);
    settle();
    chk("t3_vector", {8'h0, vec8}, 16'h0);
    chk("t3_iack", {8'h0, iack8}, 16'h0);
    chk("t3_ime", {15'h0, ime8}, 16'h0);
    drive(0, 16'h0000, 0, 0, 0, 0, 1, 0);
    settle();
    chk("t4_halted", {15'h0, halted8}, 16'h1);
    idle(16'h0010);
    settle();
    chk("t4_wake", {15'h0, halted8}, 16'h0);
    drive(0, 16'h0010, 1, 0, 0, 0, 0, 0);
    settle();
    chk("t4_no_dispatch", {15'h0, dreq8}, 16'h0);
    drive(0, 16'h0000, 0, 0, 0, 1, 0, 0);
    drive(0, 16'h0000, 0, 0, 0, 0, 1, 0);
    idle(16'h0010);
    drive(0, 16'h0010, 1, 0, 0, 0, 0, 0);
    drive(0, 16'h0010, 0, 0, 0, 0, 0, 1);
    settle();
    chk("t4_vector", {8'h0, vec8}, 16'h0060);
    chk("t4_iack", {8'h0, iack8}, 16'h0010);
    drive(0, 16'h0008, 0, 0, 0, 0, 1, 0);
    settle();
    chk("t5_halt_bug", {15'h0, hbug8}, 16'h1);
    chk("t5_not_halted", {15'h0, halted8}, 16'h0);
    idle(16'h0008);
    settle();
    chk("t5_bug_pulse", {15'h0, hbug8}, 16'h0);
    drive(0, 16'h0000, 0, 0, 0, 1, 0, 0);
    drive(0, 16'h8000, 1, 0, 0, 0, 0, 0);
    drive(0, 16'h8000, 0, 0, 0, 0, 0, 1);
    settle();
    chk("t6_vector16", {8'h0, vec16}, 16'h007C);
    chk("t6_iack16", iack16, 16'h8000);
    drive(0, 16'h0000, 0, 0, 0, 1, 0, 0);
    drive(0, 16'h0000, 0, 1, 1, 0, 0, 0);
    settle();
    chk("t6_ei_di", {15'h0, ime8}, 16'h0);
    drive(0, 16'h0000, 0, 0, 0, 1, 0, 0);
    drive(0, 16'h0001, 1, 0, 0, 0, 0, 0);
    drive(1, 16'h0001, 0, 0, 0, 0, 0, 1);
    settle();
    chk("t6_reset_dreq", {15'h0, dreq8}, 16'h0);
    chk("t6_reset_iack", {8'h0, iack8}, 16'h0);
    drive(0, 16'h0001, 0, 0, 0, 0, 0, 1);
    settle();
    chk("t6_ack_ignored", {8'h0, iack8}, 16'h0);
    for (int c = 0; c < 4000; c++) begin
      logic [15:0] iv;
      logic a;
      iv = ($urandom_range(0, 1) == 0) ? 16'h0 :
           ($urandom_range(0, 2) == 0) ? 16'($urandom) : (16'h1 << $urandom_range(0, 15));
      a = (m_mode[0] == DISP || m_mode[1] == DISP) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
      drive($urandom_range(0, 199) == 0, iv, $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
            $urandom_range(0, 11) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 11) == 0, a);
    end
    idle(16'h0);
    @(posedge clk);
    #3;
    chk("scoreboard_drained", 16'(q8.size() + q16.size()), 16'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sm83_irq_dispatch.md
Name: sm83_irq_dispatch

Overview:
- Parametrised interrupt dispatch unit for the SM83 core.
- Arbitrates N request lines with fixed lowest-index priority and manages IME, including the one-instruction EI delay.
- Handles HALT entry and wake-up, generates the one-hot acknowledge, and supplies the restart vector low byte to the control sequencer.
- Sits between the external IF&IE request vector and the core's control block; drives the core's iack bus.

Parameters:
- NUM_IRQS, 8, number of request channels; legal range 1..16.
- WORD_SIZE, 8, vector output width.
- VEC_BASE, 'h40, vector of channel 0.
- VEC_STRIDE, 8, vector spacing between channels. Elaboration check: VEC_BASE + (NUM_IRQS-1)*VEC_STRIDE < 2**WORD_SIZE.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- irq  in  NUM_IRQS  pending-and-enabled request bits (level)
- fetch_boundary  in  1  one-cycle pulse from control at the final T-cycle of each instruction (dispatch decision point)
- ei  in  1  EI executing (pulse)
- di  in  1  DI executing (pulse)
- reti  in  1  RETI executing (pulse)
- halt  in  1  HALT executing (pulse)
- ack_strobe  in  1  control's vector-resolve point inside the dispatch sequence (pulse)
- dispatch_req  out  1  control must run the interrupt sequence instead of an opcode fetch
- vector  out  WORD_SIZE  restart address low byte; high byte is 0
- iack  out  NUM_IRQS  one-hot acknowledge, one-cycle pulse
- ime  out  1  master interrupt enable
- halted  out  1  core clock-gating request
- halt_bug  out  1  one-cycle pulse: HALT not entered, PC increment must be suppressed

Behaviour:
- All outputs are registered.
- Reset (sync, high): state=RUN, ime=0, ime_pend=0, dispatch_req=0, vector=0, iack=0, halted=0, halt_bug=0. Reset overrides every other input, including mid-dispatch: no iack is issued.
- States: RUN, DISPATCH, HALT.
- IME control:
  - di: clears ime and ime_pend at the next edge.
  - reti: sets ime at the next edge and clears ime_pend.
  - ei: sets ime_pend only (no effect if ime=1).
  - On a fetch_boundary edge, ime_pend transfers to ime (ime<=1, ime_pend<=0).
  - Simultaneous di with ei or reti: di wins.
- Dispatch decision (RUN, fetch_boundary=1):
  - Uses the pre-edge ime.
  - If ime && |irq: state<=DISPATCH, dispatch_req<=1, ime<=0, ime_pend<=0.
  - Net effect: EI, one further instruction, then dispatch.
- DISPATCH:
  - dispatch_req holds 1 until ack_strobe.
  - On ack_strobe, irq is re-sampled. With k = lowest set index: vector<=VEC_BASE+k*VEC_STRIDE, iack<=1<<k for exactly one cycle.
  - If irq==0 at ack_strobe (request withdrawn), the dispatch is cancelled: vector<=0, iack stays 0.
  - On ack_strobe in either case: dispatch_req<=0, state<=RUN.
  - ei/di/reti/halt/fetch_boundary are ignored in DISPATCH.
- ack_strobe outside DISPATCH is ignored.
- vector holds its last value until the next ack_strobe.
- HALT entry (RUN, halt=1):
  - If ime=0 && |irq: halt_bug<=1 for one cycle and the state stays RUN.
  - Otherwise: state<=HALT, halted<=1.
  - halt together with fetch_boundary: the halt entry is evaluated and the dispatch decision is skipped in that cycle.
- HALT:
  - Wakes on any |irq regardless of ime: halted<=0 and state<=RUN at the next edge.
  - Dispatch then follows at the next fetch_boundary if ime=1.
  - di/ei/reti are not expected in HALT; if asserted, they are ignored.
- Priority is fixed: index 0 is highest; no rotation.

Test Plan:
1. Reset, reti, then irq=8'h14, one fetch_boundary pulse -> next cycle dispatch_req=1, ime=0; ack_strobe -> vector=8'h50, iack=8'h04 for one cycle, dispatch_req=0.
2. ime=0, ei pulse, irq=8'h01 -> no dispatch at the first fetch_boundary (ime becomes 1 on that edge); second fetch_boundary -> dispatch_req=1; ack_strobe -> vector=8'h40, iack=8'h01.
3. Dispatch pending with irq=8'h02, irq dropped to 0 before ack_strobe -> vector=8'h00, iack=0, state RUN, ime=0.
4. ime=0, irq=0, halt pulse -> halted=1; irq=8'h10 -> halted=0 next cycle, no dispatch_req; repeat with ime=1 -> dispatch at the next fetch_boundary with vector=8'h60, iack=8'h10.
5. ime=0, irq=8'h08, halt pulse -> halt_bug=1 for one cycle, halted stays 0.
6. NUM_IRQS=16, VEC_STRIDE=4, irq=16'h8000 -> vector=8'h7C, iack=16'h8000. Same cycle ei+di -> ime=0. reset asserted during DISPATCH -> dispatch_req=0, iack never pulses.
